// File: rtl/rf_write_arbiter.sv
// Purpose: merges mem-load and ALU writebacks in arrival order into one registered RF write per cycle.
// Latency: 1 cycle from accept into an empty queue; an accept at occupancy c is written c+1 cycles later.
// Backpressure: mem_ready = (c < DEPTH), alu_ready = (c < DEPTH-1); both low during flush.
// Optional feature: define RFW_HAZARD_EN to build the queued-write hazard compare for the two read ports.
module rf_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_valid,
    input  logic [2:0]    mem_reg,
    input  logic [15:0]   mem_data,
    output logic          mem_ready,
    input  logic          alu_valid,
    input  logic [2:0]    alu_reg,
    input  logic [15:0]   alu_data,
    output logic          alu_ready,
    input  logic          flush,
    input  logic [2:0]    query1_reg,
    input  logic [2:0]    query2_reg,
    output logic          hazard1,
    output logic          hazard2,
    output logic          write,
    output logic [2:0]    writeregsel,
    output logic [15:0]   writedata,
    output logic [CW-1:0] pending
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [2:0]  rg;
        logic [15:0] dat;
    } rfw_entry_t;

    rfw_entry_t          fifo_mem [DEPTH];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       count;

    logic                mem_acc;
    logic                alu_acc;
    logic                pop;
    logic                issue;
    rfw_entry_t          issue_entry;
    logic                push0_en;
    logic                push1_en;
    rfw_entry_t          push0_entry;
    rfw_entry_t          push1_entry;
    logic [1:0]          n_push;
    logic [CW-1:0]       count_nxt;
    rfw_entry_t          mem_entry;
    rfw_entry_t          alu_entry;

    // Modulo-DEPTH pointer increment; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign mem_entry = '{rg: mem_reg, dat: mem_data};
    assign alu_entry = '{rg: alu_reg, dat: alu_data};

    // The alu threshold keeps one slot free so a mem request can always land.
    assign mem_ready = !flush && (count < CW'(DEPTH));
    assign alu_ready = !flush && (count < CW'(DEPTH - 1));
    assign mem_acc   = mem_valid && mem_ready;
    assign alu_acc   = alu_valid && alu_ready;
    assign pending   = count;

    // Issue selection: queue head first, else oldest new request bypasses the queue; rest pushed mem-first.
    always_comb begin
        pop         = 1'b0;
        issue       = 1'b0;
        issue_entry = fifo_mem[rd_ptr];
        push0_en    = 1'b0;
        push1_en    = 1'b0;
        push0_entry = mem_entry;
        push1_entry = alu_entry;
        if (!flush) begin
            if (count != '0) begin
                pop   = 1'b1;
                issue = 1'b1;
                if (mem_acc) begin
                    push0_en = 1'b1;
                    push1_en = alu_acc;
                end else if (alu_acc) begin
                    push0_en    = 1'b1;
                    push0_entry = alu_entry;
                end
            end else if (mem_acc) begin
                issue       = 1'b1;
                issue_entry = mem_entry;
                if (alu_acc) begin
                    push0_en    = 1'b1;
                    push0_entry = alu_entry;
                end
            end else if (alu_acc) begin
                issue       = 1'b1;
                issue_entry = alu_entry;
            end
        end
        n_push    = {1'b0, push0_en} + {1'b0, push1_en};
        count_nxt = flush ? '0 : (count - CW'(pop) + CW'(n_push));
    end

    // Occupancy and pointers; flush empties the queue and realigns the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_nxt;
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push1_en)
                wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
            else if (push0_en)
                wr_ptr <= ptr_inc(wr_ptr);
        end
    end

    // Queue storage; a full-queue push may reuse the slot being popped this cycle.
    always_ff @(posedge clk) begin
        if (push0_en)
            fifo_mem[wr_ptr] <= push0_entry;
        if (push1_en)
            fifo_mem[ptr_inc(wr_ptr)] <= push1_entry;
    end

    // Registered RF write port; register/data hold when nothing issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write       <= 1'b0;
            writeregsel <= '0;
            writedata   <= '0;
        end else if (issue) begin
            write       <= 1'b1;
            writeregsel <= issue_entry.rg;
            writedata   <= issue_entry.dat;
        end else begin
            write       <= 1'b0;
        end
    end

`ifdef RFW_HAZARD_EN
    // Compare both read selects against every live queue entry; the output regs are bypassed by the RF.
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            int off;
            off = (i >= int'(rd_ptr)) ? (i - int'(rd_ptr)) : (i + DEPTH - int'(rd_ptr));
            if (off < int'(count)) begin
                if (fifo_mem[i].rg == query1_reg)
                    hazard1 = 1'b1;
                if (fifo_mem[i].rg == query2_reg)
                    hazard2 = 1'b1;
            end
        end
    end
`else
    wire unused_query = ^{query1_reg, query2_reg};
    assign hazard1 = 1'b0;
    assign hazard2 = 1'b0;
`endif

`ifndef SYNTHESIS
    // Pushes may never exceed the free space left after this cycle's pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (int'(n_push) <= DEPTH - int'(count) + int'(pop)));
`endif

endmodule
